// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: alignment check, lane steering and a
// request/response handshake to the data bus, stalling the pipeline until done.
module mem_lsu #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid_i,
  input  logic [3:0]        ram_op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       store_data_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              load_valid_o,
  output logic [31:0]       load_data_o,
  output logic              exc_valid_o,
  output logic [4:0]        exc_code_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W/8-1:0] bus_be_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ready_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_err_i
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         op_q;
  logic [LANE_W-1:0]  lane_q;
  logic               err_q;

  logic               is_load, is_store, misaligned, valid_op, accept, addr_exc;
  size_t              size;
  logic [LANE_W-1:0]  lane;
  logic [NB-1:0]      be_mask;
  logic [31:0]        wsel;
  logic [DATA_W-1:0]  rshift;
  logic [31:0]        load_ext;
  logic               load_q, timeout_hit;

  // NOTE: every variable driven here gets a default first so no path can infer a latch.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = SZ_B;
    case (ram_op_i)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin is_load = 1'b1; size = SZ_H; end
      OP_LW:         begin is_load = 1'b1; size = SZ_W; end
      OP_SB:         is_store = 1'b1;
      OP_SH:         begin is_store = 1'b1; size = SZ_H; end
      OP_SW:         begin is_store = 1'b1; size = SZ_W; end
      default:       ;
    endcase
  end

  assign lane       = addr_i[LANE_W-1:0];
  assign misaligned = ((size == SZ_H) && addr_i[0]) ||
                      ((size == SZ_W) && (addr_i[1:0] != 2'b00));
  assign valid_op   = op_valid_i && (is_load || is_store) && !flush_i;
  assign accept     = (state == S_IDLE) && valid_op && !misaligned;
  assign addr_exc   = (state == S_IDLE) && valid_op && misaligned;

  always_comb begin
    be_mask = NB'(1);
    wsel    = {24'd0, store_data_i[7:0]};
    case (size)
      SZ_H: begin be_mask = NB'(3);  wsel = {16'd0, store_data_i[15:0]}; end
      SZ_W: begin be_mask = NB'(15); wsel = store_data_i; end
      default: ;
    endcase
  end

  // Response lanes are steered down to bit 0 before extension.
  assign rshift = bus_rdata_i >> {lane_q, 3'b000};

  always_comb begin
    load_ext = rshift[31:0];
    case (op_q)
      OP_LB:  load_ext = {{24{rshift[7]}}, rshift[7:0]};
      OP_LBU: load_ext = {24'd0, rshift[7:0]};
      OP_LH:  load_ext = {{16{rshift[15]}}, rshift[15:0]};
      OP_LHU: load_ext = {16'd0, rshift[15:0]};
      default: ;
    endcase
  end

  assign load_q      = (op_q >= OP_LB) && (op_q <= OP_LW);
  assign timeout_hit = (TIMEOUT > 0) && (cnt == CNT_W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_q        <= '0;
      lane_q      <= '0;
      err_q       <= 1'b0;
      load_data_o <= '0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= '0;
      bus_wdata_o <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          state       <= S_REQ;
          op_q        <= ram_op_i;
          lane_q      <= lane;
          bus_we_o    <= is_store;
          bus_addr_o  <= addr_i & ~ADDR_W'(NB - 1);
          bus_be_o    <= be_mask << lane;
          bus_wdata_o <= DATA_W'(wsel) << {lane, 3'b000};
        end
        S_REQ: begin
          // An accepted request owes a response, so a simultaneous flush must drain it.
          if (bus_ready_i) begin
            cnt   <= '0;
            state <= flush_i ? S_DRAIN : S_WAIT;
          end else if (flush_i) begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (bus_rvalid_i) begin
            err_q <= bus_err_i;
            if (load_q && !bus_err_i) load_data_o <= load_ext;
            state <= S_DONE;
          end else if (flush_i) begin
            state <= S_DRAIN;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DRAIN: if (bus_rvalid_i) state <= S_IDLE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stall_o      = !rst && (accept || (state == S_REQ) || (state == S_WAIT));
  assign bus_req_o    = !rst && (state == S_REQ);
  assign load_valid_o = !rst && (state == S_DONE) && load_q && !err_q;

  always_comb begin
    exc_valid_o = 1'b0;
    exc_code_o  = 5'd0;
    if (!rst) begin
      if (addr_exc) begin
        exc_valid_o = 1'b1;
        exc_code_o  = is_store ? EXC_ADES : EXC_ADEL;
      end else if ((state == S_DONE) && err_q) begin
        exc_valid_o = 1'b1;
        exc_code_o  = EXC_DBE;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: loads, stores, alignment faults, bus error,
// timeout, flush and reset mid-transfer.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid_i = 1'b0;
  logic [3:0]  ram_op_i = '0;
  logic [31:0] addr_i = '0;
  logic [31:0] store_data_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o, load_valid_o, exc_valid_o;
  logic [31:0] load_data_o;
  logic [4:0]  exc_code_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ready_i = 1'b0;
  logic        bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_err_i = 1'b0;

  int checks = 0;
  int errors = 0;

  mem_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .ram_op_i(ram_op_i),
    .addr_i(addr_i), .store_data_i(store_data_i), .flush_i(flush_i),
    .stall_o(stall_o), .load_valid_o(load_valid_o), .load_data_o(load_data_o),
    .exc_valid_o(exc_valid_o), .exc_code_o(exc_code_o), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o), .bus_ready_i(bus_ready_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transfer with immediate ready and a response in the first WAIT cycle.
  task automatic transfer(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata, input logic err,
                          input logic exp_we, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic exp_lv,
                          input logic [31:0] exp_ld, input logic exp_exc);
    op_valid_i = 1'b1; ram_op_i = op; addr_i = addr; store_data_i = sdata;
    bus_ready_i = 1'b1; bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
    @(negedge clk);
    check({tag, " accept stall"}, stall_o, 1'b1);
    check({tag, " accept req"}, bus_req_o, 1'b0);
    tick();
    @(negedge clk);
    check({tag, " req"}, bus_req_o, 1'b1);
    check({tag, " we"}, bus_we_o, exp_we);
    check({tag, " be"}, bus_be_o, exp_be);
    check({tag, " addr"}, bus_addr_o, addr & 32'hFFFF_FFFC);
    if (exp_we) check({tag, " wdata"}, bus_wdata_o, exp_wdata);
    check({tag, " req stall"}, stall_o, 1'b1);
    tick();
    bus_rvalid_i = 1'b1; bus_rdata_i = rdata; bus_err_i = err;
    @(negedge clk);
    check({tag, " wait stall"}, stall_o, 1'b1);
    check({tag, " wait req"}, bus_req_o, 1'b0);
    tick();
    bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
    @(negedge clk);
    check({tag, " done stall"}, stall_o, 1'b0);
    check({tag, " done load_valid"}, load_valid_o, exp_lv);
    if (exp_lv) check({tag, " done load_data"}, load_data_o, exp_ld);
    check({tag, " done exc_valid"}, exc_valid_o, exp_exc);
    if (exp_exc) check({tag, " done exc_code"}, exc_code_o, 5'd7);
    tick();
    op_valid_i = 1'b0;
    @(negedge clk);
    check({tag, " no reaccept"}, bus_req_o, 1'b0);
    check({tag, " idle stall"}, stall_o, 1'b0);
    tick();
  endtask

  initial begin
    // Reset, with an op presented to show it is ignored
    op_valid_i = 1'b1; ram_op_i = 4'd5; addr_i = 32'h100;
    @(negedge clk);
    check("rst stall", stall_o, 1'b0);
    check("rst req", bus_req_o, 1'b0);
    check("rst load_valid", load_valid_o, 1'b0);
    check("rst exc", {exc_valid_o, exc_code_o}, 6'd0);
    tick();
    @(negedge clk);
    check("rst bus fields", {bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o}, 69'd0);
    check("rst load_data", load_data_o, 32'd0);
    op_valid_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // 1: LW
    transfer("lw", 4'd5, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'hF, 32'h0,
             1'b1, 32'hDEAD_BEEF, 1'b0);
    // 2: LB / LBU on top lane
    transfer("lb", 4'd1, 32'h103, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 4'h8, 32'h0,
             1'b1, 32'hFFFF_FF80, 1'b0);
    transfer("lbu", 4'd2, 32'h103, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 4'h8, 32'h0,
             1'b1, 32'h0000_0080, 1'b0);
    transfer("lh", 4'd3, 32'h102, 32'h0, 32'h8001_1234, 1'b0, 1'b0, 4'hC, 32'h0,
             1'b1, 32'hFFFF_8001, 1'b0);
    // 3: SH upper half
    transfer("sh", 4'd7, 32'h202, 32'h0000_1234, 32'h0, 1'b0, 1'b1, 4'hC,
             32'h1234_0000, 1'b0, 32'h0, 1'b0);
    transfer("sb", 4'd6, 32'h201, 32'hAABB_CCDD, 32'h0, 1'b0, 1'b1, 4'h2,
             32'h0000_DD00, 1'b0, 32'h0, 1'b0);
    // 5a: bus error on response
    transfer("lw err", 4'd5, 32'h100, 32'h0, 32'h1234_5678, 1'b1, 1'b0, 4'hF, 32'h0,
             1'b0, 32'h0, 1'b1);

    // 4: misaligned LW then SW
    op_valid_i = 1'b1; ram_op_i = 4'd5; addr_i = 32'h101;
    @(negedge clk);
    check("adel exc", {exc_valid_o, exc_code_o}, {1'b1, 5'd4});
    check("adel stall", stall_o, 1'b0);
    check("adel req", bus_req_o, 1'b0);
    tick();
    @(negedge clk);
    check("adel req later", bus_req_o, 1'b0);
    ram_op_i = 4'd8; addr_i = 32'h102;
    #1;
    check("ades exc", {exc_valid_o, exc_code_o}, {1'b1, 5'd5});
    check("ades stall", stall_o, 1'b0);
    tick();
    op_valid_i = 1'b0;
    @(negedge clk);
    check("ades req later", bus_req_o, 1'b0);
    check("idle exc", exc_valid_o, 1'b0);
    tick();

    // Flush in IDLE accepts nothing
    op_valid_i = 1'b1; ram_op_i = 4'd5; addr_i = 32'h100; flush_i = 1'b1;
    @(negedge clk);
    check("flush idle stall", stall_o, 1'b0);
    tick();
    op_valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    check("flush idle req", bus_req_o, 1'b0);
    tick();

    // REQ held without ready, then flushed before acceptance
    op_valid_i = 1'b1; ram_op_i = 4'd5; addr_i = 32'h300; bus_ready_i = 1'b0;
    tick();
    @(negedge clk);
    check("req hold 1", bus_req_o, 1'b1);
    tick();
    @(negedge clk);
    check("req hold 2", {bus_req_o, bus_addr_o}, {1'b1, 32'h300});
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; op_valid_i = 1'b0;
    @(negedge clk);
    check("req flush drop", {bus_req_o, stall_o}, 2'b00);
    tick();

    // 5b: timeout after 4 WAIT cycles
    op_valid_i = 1'b1; ram_op_i = 4'd5; addr_i = 32'h100; bus_ready_i = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("timeout wait %0d stall", i + 1), stall_o, 1'b1);
      tick();
    end
    @(negedge clk);
    check("timeout exc", {exc_valid_o, exc_code_o}, {1'b1, 5'd7});
    check("timeout stall", stall_o, 1'b0);
    check("timeout load_valid", load_valid_o, 1'b0);
    tick();
    op_valid_i = 1'b0;
    tick();

    // 6a: flush in WAIT, late response discarded, no new op taken in DRAIN
    op_valid_i = 1'b1; ram_op_i = 4'd5; addr_i = 32'h100;
    tick();
    tick();
    flush_i = 1'b1;
    @(negedge clk);
    check("flush wait stall", stall_o, 1'b1);
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    check("drain stall", stall_o, 1'b0);
    check("drain exc", exc_valid_o, 1'b0);
    tick();
    op_valid_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1111_1111;
    @(negedge clk);
    check("drain no accept", bus_req_o, 1'b0);
    check("drain load_valid", load_valid_o, 1'b0);
    tick();
    bus_rvalid_i = 1'b0;
    @(negedge clk);
    check("post drain", {load_valid_o, bus_req_o, stall_o}, 3'b000);
    tick();

    // 6b: reset in REQ abandons the transfer; stray response ignored
    op_valid_i = 1'b1; ram_op_i = 4'd5; addr_i = 32'h100; bus_ready_i = 1'b0;
    tick();
    @(negedge clk);
    check("rst req before", bus_req_o, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0; op_valid_i = 1'b0;
    @(negedge clk);
    check("rst req after", {bus_req_o, stall_o}, 2'b00);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h2222_2222;
    tick();
    bus_rvalid_i = 1'b0;
    @(negedge clk);
    check("stray rvalid", {load_valid_o, exc_valid_o, bus_req_o}, 3'b000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
